// File: rtl/noc_pkg.sv
// Shared flit definitions for the mesh NoC router ports.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: none.
package noc_pkg;

    localparam int FLIT_TYPE_W = 2;
    localparam int FLIT_MAX_W  = 1024;

    localparam logic [FLIT_TYPE_W-1:0] FLIT_BODY   = 2'b00;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_HEAD   = 2'b01;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_TAIL   = 2'b10;
    localparam logic [FLIT_TYPE_W-1:0] FLIT_SINGLE = 2'b11;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_t;

    // Callers zero-extend the flit to FLIT_MAX_W and pass its real width.
    function automatic logic [FLIT_TYPE_W-1:0] flit_type(
        input logic [FLIT_MAX_W-1:0] data,
        input int unsigned           data_w
    );
        logic [FLIT_MAX_W-1:0] shifted;
        shifted = data >> (data_w - FLIT_TYPE_W);
        return shifted[FLIT_TYPE_W-1:0];
    endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC circular flit buffer with head->tail packet lock tracking.
// Latency: push visible at head next cycle; ack and lock are registered (1 cycle after pop).
// Backpressure: push while full and pop while empty are ignored; full is the upstream contract.
module noc_vc_fifo
    import noc_pkg::*;
#(
    parameter int  DATA_W = 35,
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              ack,
    output logic              lock
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   push_ok;
    logic                   pop_ok;
    logic [FLIT_TYPE_W-1:0] head_type;
    lock_state_t            state_q;
    lock_state_t            state_d;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    // Empty VCs present zero so the head bus is deterministic out of reset.
    assign head_dat = empty ? '0 : mem[rd_ptr];
    assign head_type = flit_type(FLIT_MAX_W'(head_dat), DATA_W);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ack    <= 1'b0;
        end else begin
            ack <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOCK_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Only HEAD opens and only TAIL closes; SINGLE, stray BODY/TAIL and nested HEAD leave state alone.
    always_comb begin
        state_d = state_q;
        if (pop_ok) begin
            case (state_q)
                LOCK_IDLE: if (head_type == FLIT_HEAD) state_d = LOCK_HELD;
                LOCK_HELD: if (head_type == FLIT_TAIL) state_d = LOCK_IDLE;
                default:   state_d = LOCK_IDLE;
            endcase
        end
    end

    always_comb begin
        lock = (state_q == LOCK_HELD);
    end

endmodule

// File: rtl/noc_vc_input_buffer.sv
// Router input port: steers flits into NUM_VC FIFOs, exposes heads, returns credits; NOC_VCBUF_OVERFLOW_CHECK_EN enables sticky OERR.
// Latency: 1 cycle write-to-head; OACK/OLCK/OERR registered, 1 cycle after the causing event.
// Backpressure: ORDY per VC from registered count; writes to a full or nonexistent VC are dropped.
module noc_vc_input_buffer
    import noc_pkg::*;
#(
    parameter int  DATA_W = 35,
    parameter int  NUM_VC = 2,
    parameter int  DEPTH  = 4,
    localparam int VCH_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                     clk,
    input  logic                     RST_,
    input  logic [DATA_W-1:0]        IDATA,
    input  logic                     IVALID,
    input  logic [VCH_W-1:0]         IVCH,
    output logic [NUM_VC-1:0]        ORDY,
    output logic [NUM_VC-1:0]        OACK,
    output logic [NUM_VC-1:0]        HVALID,
    output logic [NUM_VC*DATA_W-1:0] HDATA,
    input  logic [NUM_VC-1:0]        IPOP,
    output logic [NUM_VC-1:0]        OLCK,
    output logic                     OERR
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_VC-1:0] vc_sel;
    logic [NUM_VC-1:0] push;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [CNT_W-1:0]  count [NUM_VC];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        // Out-of-range IVCH matches no VC, so it is dropped here without extra logic.
        assign vc_sel[v] = IVALID && (32'(IVCH) == v);
        assign push[v]   = vc_sel[v] && !full[v];
        assign ORDY[v]   = (count[v] < CNT_W'(DEPTH));
        assign HVALID[v] = !empty[v];

        noc_vc_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (RST_),
            .push     (push[v]),
            .push_dat (IDATA),
            .pop      (IPOP[v]),
            .head_dat (HDATA[v*DATA_W +: DATA_W]),
            .count    (count[v]),
            .full     (full[v]),
            .empty    (empty[v]),
            .ack      (OACK[v]),
            .lock     (OLCK[v])
        );
    end

`ifdef NOC_VCBUF_OVERFLOW_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge RST_) begin
        if (!RST_) begin
            err_q <= 1'b0;
        end else if (IVALID && !(|push)) begin
            err_q <= 1'b1;
        end
    end

    assign OERR = err_q;
`else
    assign OERR = 1'b0;
`endif

endmodule
